// File: rtl/poseidon_pkg.sv
// poseidon_pkg: shared widths, element type and deserializer state encoding for the Poseidon input path.
package poseidon_pkg;
  localparam int ELEM_WIDTH = 255;
  localparam int STATE_SIZE = 9;
  localparam int CNT_WIDTH  = 4;
  localparam int STAT_WIDTH = 16;
  typedef logic [ELEM_WIDTH-1:0] elem_t;
  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;
endpackage

// File: rtl/poseidon_input_deserializer.sv
// poseidon_input_deserializer: gathers STATE_SIZE element beats into one state vector, drops malformed frames.
module poseidon_input_deserializer
  import poseidon_pkg::*;
(
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             io_input_valid,
  output logic                             io_input_ready,
  input  logic                             io_input_last,
  input  logic [ELEM_WIDTH-1:0]            io_input_payload,
  output logic                             io_state_valid,
  input  logic                             io_state_ready,
  output logic [STATE_SIZE*ELEM_WIDTH-1:0] io_state_payload,
  output logic                             err_short,
  output logic                             err_long,
  output logic [STAT_WIDTH-1:0]            frame_count,
  output logic [STAT_WIDTH-1:0]            error_count
);
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] idx, idx_nxt;
  logic in_hs, out_hs, at_end, wr, short_nxt, long_nxt;
  assign io_input_ready = (state != HOLD) && resetn;
  assign io_state_valid = state == HOLD;
  assign in_hs = io_input_valid && io_input_ready;
  assign out_hs = io_state_valid && io_state_ready;
  assign at_end = idx == CNT_WIDTH'(STATE_SIZE - 1);
  assign wr = in_hs && state == COLLECT;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    short_nxt = 1'b0;
    long_nxt = 1'b0;
    case (state)
      COLLECT: if (in_hs) begin
        idx_nxt = (at_end || io_input_last) ? '0 : idx + 1'b1;
        short_nxt = !at_end && io_input_last;
        long_nxt = at_end && !io_input_last;
        state_nxt = at_end ? (io_input_last ? HOLD : DISCARD) : COLLECT;
      end
      HOLD: state_nxt = out_hs ? COLLECT : HOLD;
      DISCARD: state_nxt = (in_hs && io_input_last) ? COLLECT : DISCARD;
      default: state_nxt = COLLECT;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= COLLECT;
      idx <= '0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      err_short <= short_nxt;
      err_long <= long_nxt;
      if (out_hs) frame_count <= frame_count + 1'b1;
      if ((short_nxt || long_nxt) && !(&error_count)) error_count <= error_count + 1'b1;
    end
  end
  // Slots are only written while collecting, so a held frame stays stable until accepted.
  for (genvar i = 0; i < STATE_SIZE; i++) begin : g_slot
    logic [ELEM_WIDTH-1:0] q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) q <= '0;
      else if (wr && idx == CNT_WIDTH'(i)) q <= io_input_payload;
    end
    assign io_state_payload[ELEM_WIDTH*i +: ELEM_WIDTH] = q;
  end
endmodule

// File: tb/tb_poseidon_input_deserializer.sv
// tb_poseidon_input_deserializer: directed and randomized frames checked against a queue-based framing model.
module tb_poseidon_input_deserializer;
  import poseidon_pkg::*;
  typedef logic [STATE_SIZE*ELEM_WIDTH-1:0] frame_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic io_input_valid = 1'b0, io_input_last = 1'b0, io_state_ready = 1'b0;
  elem_t io_input_payload = '0;
  logic io_input_ready, io_state_valid, err_short, err_long;
  frame_t io_state_payload;
  logic [STAT_WIDTH-1:0] frame_count, error_count;

  poseidon_input_deserializer dut (
    .clk(clk), .resetn(resetn),
    .io_input_valid(io_input_valid), .io_input_ready(io_input_ready),
    .io_input_last(io_input_last), .io_input_payload(io_input_payload),
    .io_state_valid(io_state_valid), .io_state_ready(io_state_ready),
    .io_state_payload(io_state_payload),
    .err_short(err_short), .err_long(err_long),
    .frame_count(frame_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int short_cnt = 0, long_cnt = 0, both_cnt = 0, stab_err = 0;
  frame_t got_q[$];
  int got_cyc[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  frame_t prev_p = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation only: deliveries, error pulses and output stability, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (io_state_valid && io_state_ready) begin
        got_q.push_back(io_state_payload);
        got_cyc.push_back(cyc);
      end
      if (err_short) short_cnt++;
      if (err_long) long_cnt++;
      if (err_short && err_long) both_cnt++;
      if (prev_v && !prev_r && (!io_state_valid || io_state_payload !== prev_p)) stab_err++;
    end
    prev_v = io_state_valid && resetn;
    prev_r = io_state_ready;
    prev_p = io_state_payload;
  end

  // Reference model: a frame is a run of beats ending at last; exactly STATE_SIZE beats is good.
  elem_t cur[$];
  frame_t exp_q[$];
  bit discarding = 0;
  int exp_total = 0, exp_err = 0;
  bit rnd_mode = 0;

  function automatic void model_beat(input elem_t d, input logic l);
    frame_t f;
    if (discarding) begin
      if (l) discarding = 0;
      return;
    end
    cur.push_back(d);
    if (cur.size() == STATE_SIZE) begin
      if (l) begin
        for (int i = 0; i < STATE_SIZE; i++) f[i*ELEM_WIDTH +: ELEM_WIDTH] = cur[i];
        exp_q.push_back(f);
        exp_total++;
      end else begin
        exp_err++;
        discarding = 1;
      end
      cur.delete();
    end else if (l) begin
      exp_err++;
      cur.delete();
    end
  endfunction

  function automatic elem_t rnd_elem();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[ELEM_WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input elem_t obs, input elem_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) io_state_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic beat(input elem_t d, input logic l);
    bit acc;
    int budget;
    if (rnd_mode) repeat ($urandom_range(0, 2)) step();
    io_input_valid = 1'b1;
    io_input_payload = d;
    io_input_last = l;
    acc = 0;
    budget = 200;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = io_input_ready;
      step();
      budget--;
    end
    if (!acc) check("beat_accept_timeout", elem_t'(acc), elem_t'(1));
    else model_beat(d, l);
    io_input_valid = 1'b0;
    io_input_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int k = 0; k < n; k++) beat(rnd_elem(), k == last_at);
  endtask

  task automatic drain_and_compare(input string tag);
    io_state_ready = 1'b1;
    repeat (4) step();
    check({tag, "_count"}, elem_t'(got_q.size()), elem_t'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_frame"}, elem_t'(got_q[i] === exp_q[i]), elem_t'(1));
    check({tag, "_frame_count"}, elem_t'(frame_count), elem_t'(exp_total % 65536));
    check({tag, "_error_count"}, elem_t'(error_count), elem_t'(exp_err > 65535 ? 65535 : exp_err));
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    elem_t e0, held;
    int s0, l0;
    e0 = 255'hc59041b7aa57a3757c9e652d111ec48d5f04d67039bae3300000232fffffdcd;
    #1;
    check("rst_input_ready", elem_t'(io_input_ready), elem_t'(0));
    check("rst_state_valid", elem_t'(io_state_valid), elem_t'(0));
    check("rst_payload_zero", elem_t'(io_state_payload == '0), elem_t'(1));
    check("rst_errs", elem_t'({err_short, err_long}), elem_t'(0));
    check("rst_counts", elem_t'({frame_count, error_count}), elem_t'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();

    // single frame, latency and first element placement
    beat(e0, 1'b0);
    for (int k = 1; k < STATE_SIZE; k++) begin
      check("t1_valid_early", elem_t'(io_state_valid), elem_t'(0));
      beat(rnd_elem(), k == STATE_SIZE - 1);
    end
    check("t1_valid_latency", elem_t'(io_state_valid), elem_t'(1));
    check("t1_elem0", io_state_payload[ELEM_WIDTH-1:0], e0);
    io_state_ready = 1'b1;
    step();
    check("t1_frame_count", elem_t'(frame_count), elem_t'(1));
    check("t1_valid_cleared", elem_t'(io_state_valid), elem_t'(0));
    drain_and_compare("t1");

    // ten back-to-back frames at peak rate
    for (int f = 0; f < 10; f++) send_frame(STATE_SIZE, STATE_SIZE - 1);
    repeat (3) step();
    for (int i = 1; i < got_cyc.size(); i++)
      check("t2_frame_period", elem_t'(got_cyc[i] - got_cyc[i-1]), elem_t'(STATE_SIZE + 1));
    drain_and_compare("t2");

    // backpressure in HOLD
    io_state_ready = 1'b0;
    send_frame(STATE_SIZE, STATE_SIZE - 1);
    held = io_state_payload[ELEM_WIDTH*STATE_SIZE-1 -: ELEM_WIDTH];
    repeat (20) begin
      @(negedge clk);
      check("t3_hold_ready", elem_t'(io_input_ready), elem_t'(0));
      check("t3_hold_payload", io_state_payload[ELEM_WIDTH*STATE_SIZE-1 -: ELEM_WIDTH], held);
    end
    @(posedge clk);
    #1 io_state_ready = 1'b1;
    check("t3_ready_before_hs", elem_t'(io_input_ready), elem_t'(0));
    @(posedge clk);
    #1;
    check("t3_ready_after_hs", elem_t'(io_input_ready), elem_t'(1));
    drain_and_compare("t3");

    // short frame then good frame
    s0 = short_cnt;
    l0 = long_cnt;
    send_frame(4, 3);
    send_frame(STATE_SIZE, STATE_SIZE - 1);
    drain_and_compare("t4");
    check("t4_short_pulses", elem_t'(short_cnt - s0), elem_t'(1));
    check("t4_long_pulses", elem_t'(long_cnt - l0), elem_t'(0));

    // long frame then good frame
    s0 = short_cnt;
    l0 = long_cnt;
    send_frame(12, 11);
    send_frame(STATE_SIZE, STATE_SIZE - 1);
    drain_and_compare("t5");
    check("t5_long_pulses", elem_t'(long_cnt - l0), elem_t'(1));
    check("t5_short_pulses", elem_t'(short_cnt - s0), elem_t'(0));

    // reset mid-frame
    send_frame(5, -1);
    resetn = 1'b0;
    #1;
    check("t6_rst_input_ready", elem_t'(io_input_ready), elem_t'(0));
    check("t6_rst_state_valid", elem_t'(io_state_valid), elem_t'(0));
    check("t6_rst_payload_zero", elem_t'(io_state_payload == '0), elem_t'(1));
    check("t6_rst_counts", elem_t'({frame_count, error_count}), elem_t'(0));
    cur.delete();
    discarding = 0;
    exp_total = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    s0 = short_cnt;
    l0 = long_cnt;
    send_frame(STATE_SIZE, STATE_SIZE - 1);
    drain_and_compare("t6");
    check("t6_no_err_pulse", elem_t'((short_cnt - s0) + (long_cnt - l0)), elem_t'(0));

    // randomized frame lengths, gaps and backpressure
    rnd_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 12);
      send_frame(n, n - 1);
    end
    rnd_mode = 0;
    drain_and_compare("rnd");

    check("never_both_errors", elem_t'(both_cnt), elem_t'(0));
    check("output_stability", elem_t'(stab_err), elem_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
